// File: rtl/address_generator_cofactor_hs_pkg.sv
// Shared types and constants for the cofactor address generator.
// Optional statistics counters are enabled with ADDR_GEN_COFACTOR_STATS_EN.
package cofactor_pkg;

   localparam int KIND_W = 2;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_BASE = 3'd3;
   localparam logic [2:0] ST_PAIR = 3'd4;
   localparam logic [2:0] ST_NEW  = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   typedef enum logic [KIND_W-1:0] {
      KIND_BASE = 2'd0,
      KIND_PAIR = 2'd1,
      KIND_NEW  = 2'd2
   } addr_kind_t;

endpackage

// File: rtl/address_generator_cofactor_hs_stats.sv
// Three saturating event counters for PAIR transfers, NEW transfers and
// skipped entries; cleared at every pass start. Built only under ADDR_GEN_COFACTOR_STATS_EN.
module cofactor_stats_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc_pair,
   input  logic         inc_new,
   input  logic         inc_skip,
   output logic [W-1:0] stat_pair,
   output logic [W-1:0] stat_new,
   output logic [W-1:0] stat_skip
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_pair <= '0;
         stat_new  <= '0;
         stat_skip <= '0;
      end else if (clr) begin
         stat_pair <= '0;
         stat_new  <= '0;
         stat_skip <= '0;
      end else begin
         if (inc_pair && stat_pair != '1) stat_pair <= stat_pair + ONE;
         if (inc_new  && stat_new  != '1) stat_new  <= stat_new  + ONE;
         if (inc_skip && stat_skip != '1) stat_skip <= stat_skip + ONE;
      end
   end

endmodule

// File: rtl/address_generator_cofactor_hs.sv
// Cofactor address generator: walks the amplitude vector issuing BASE then PAIR/NEW
// read addresses with ready/valid backpressure. Optional stats: ADDR_GEN_COFACTOR_STATS_EN.
module address_generator_cofactor_hs
   import cofactor_pkg::*;
#(
   parameter int NUM_QUBIT = 3,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 index_fifo_empty,
   input  logic [NUM_QUBIT:0]   index_in,
   output logic                 read_index,
   input  logic [CNT_W-1:0]     counter_vector,
   output logic [NUM_QUBIT-1:0] read_address,
   output logic [KIND_W-1:0]    address_kind,
   output logic                 address_valid,
   input  logic                 address_ready,
   output logic [CNT_W-1:0]     counter_vector_out,
   output logic                 done,
`ifdef ADDR_GEN_COFACTOR_STATS_EN
   output logic [CNT_W-1:0]     stat_pair,
   output logic [CNT_W-1:0]     stat_new,
   output logic [CNT_W-1:0]     stat_skip,
`endif
   output logic                 overflow
);

   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CAPACITY = ONE << NUM_QUBIT;

   logic [2:0]           state;
   logic [CNT_W-1:0]     vec_len;
   logic [CNT_W-1:0]     vec_upd;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_QUBIT-1:0] idx_reg;
   logic                 pair_pend;
   logic                 overflow_q;

   logic                 handshake;
   logic                 last_entry;
   logic                 pass_start;
   logic                 cap_skip;
   logic [CNT_W-1:0]     idx_ext;

   assign handshake  = address_valid && address_ready;
   // Compared against the pre-increment count, so vec_len entries are consumed per pass.
   assign last_entry = (cnt == vec_len - ONE);
   assign pass_start = (state == ST_IDLE) && !index_fifo_empty;
   assign idx_ext    = {{(CNT_W-NUM_QUBIT){1'b0}}, index_in[NUM_QUBIT-1:0]};
   assign cap_skip   = (state == ST_CAP) && index_in[NUM_QUBIT] && !(idx_ext > cnt);

   // NOTE: state registers use non-blocking (<=) so every branch reads pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         vec_len    <= '0;
         vec_upd    <= '0;
         cnt        <= '0;
         idx_reg    <= '0;
         pair_pend  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (pass_start) begin
               vec_len    <= counter_vector;
               vec_upd    <= counter_vector;
               cnt        <= '0;
               overflow_q <= 1'b0;
               state      <= (counter_vector == '0) ? ST_DONE : ST_REQ;
            end
            ST_REQ: if (!index_fifo_empty) state <= ST_CAP;
            ST_CAP: begin
               idx_reg <= index_in[NUM_QUBIT-1:0];
               if (cap_skip) begin
                  cnt   <= cnt + ONE;
                  state <= last_entry ? ST_DONE : ST_REQ;
               end else begin
                  pair_pend <= index_in[NUM_QUBIT];
                  state     <= ST_BASE;
               end
            end
            ST_BASE: if (handshake) begin
               if (pair_pend) begin
                  state <= ST_PAIR;
               end else if (vec_upd < CAPACITY) begin
                  state <= ST_NEW;
               end else begin
                  // Vector is full: drop the append and close the entry here.
                  overflow_q <= 1'b1;
                  cnt        <= cnt + ONE;
                  state      <= last_entry ? ST_DONE : ST_REQ;
               end
            end
            ST_PAIR: if (handshake) begin
               cnt   <= cnt + ONE;
               state <= last_entry ? ST_DONE : ST_REQ;
            end
            ST_NEW: if (handshake) begin
               vec_upd <= vec_upd + ONE;
               cnt     <= cnt + ONE;
               state   <= last_entry ? ST_DONE : ST_REQ;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      address_valid = 1'b0;
      read_address  = '0;
      address_kind  = KIND_BASE;
      case (state)
         ST_BASE: begin
            address_valid = 1'b1;
            read_address  = cnt[NUM_QUBIT-1:0];
         end
         ST_PAIR: begin
            address_valid = 1'b1;
            read_address  = idx_reg;
            address_kind  = KIND_PAIR;
         end
         ST_NEW: begin
            address_valid = 1'b1;
            read_address  = vec_upd[NUM_QUBIT-1:0];
            address_kind  = KIND_NEW;
         end
         default: ;
      endcase
   end

   assign read_index         = (state == ST_REQ) && !index_fifo_empty;
   assign done               = (state == ST_DONE);
   assign overflow           = overflow_q;
   // vec_upd only moves during a pass, so it already holds the result after DONE.
   assign counter_vector_out = vec_upd;

`ifdef ADDR_GEN_COFACTOR_STATS_EN
   cofactor_stats_counter #(.W(CNT_W)) u_stats (
      .clk       (clk),
      .rst       (rst),
      .clr       (pass_start),
      .inc_pair  ((state == ST_PAIR) && handshake),
      .inc_new   ((state == ST_NEW) && handshake),
      .inc_skip  (cap_skip),
      .stat_pair (stat_pair),
      .stat_new  (stat_new),
      .stat_skip (stat_skip)
   );
`endif

endmodule
